// File: rtl/apb4_protocol_monitor.sv
// apb4_protocol_monitor
// Passive APB4 bus monitor: tracks IDLE/SETUP/ACCESS, latches protocol
// violations into a sticky, write-1-to-clear error vector, and keeps
// saturating transfer / error-response / wait-state statistics.
// Optional feature macro: APB_ADDR_MAP_CHECK_EN enables error bit 7
// (PSLVERR versus the legal address range at completion).
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | no transfer in flight
// ST_SETUP  | setup phase seen, fields captured
// ST_ACCESS | access phase in progress, waiting on PREADY
//
// err bit | name
// 0 SETUP_NO_ACCESS, 1 UNSTABLE, 2 ORPHAN_ENABLE, 3 MULTI_SEL,
// 4 TIMEOUT, 5 STRB_ON_READ, 6 READY_IN_SETUP, 7 ADDR_MAP
module apb4_protocol_monitor #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SEL        = 4,
  parameter int MAX_WAIT       = 16,
  parameter int LEGAL_ADDR_MAX = 255
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [NUM_SEL-1:0]      PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic                    PREADY,
  input  logic                    PSLVERR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic [2:0]              PPROT,
  input  logic [7:0]              err_clr,
  output logic [7:0]              err_sticky,
  output logic                    err_irq,
  output logic [1:0]              mon_state,
  output logic [15:0]             xfer_cnt,
  output logic [15:0]             slverr_cnt,
  output logic [7:0]              max_wait_seen
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } mon_state_e;

  localparam logic [15:0] MAX_WAIT_L = 16'(MAX_WAIT);

  mon_state_e              state_q, state_d;
  logic [15:0]             wait_q, wait_d;
  logic [ADDR_WIDTH-1:0]   cap_addr_q, cap_addr_d;
  logic                    cap_write_q, cap_write_d;
  logic [NUM_SEL-1:0]      cap_sel_q, cap_sel_d;
  logic [2:0]              cap_prot_q, cap_prot_d;
  logic [DATA_WIDTH/8-1:0] cap_strb_q, cap_strb_d;
  logic [DATA_WIDTH-1:0]   cap_wdata_q, cap_wdata_d;
  logic [7:0]              err_q, err_d;
  logic [15:0]             xfer_q, xfer_d;
  logic [15:0]             slverr_q, slverr_d;
  logic [7:0]              maxw_q, maxw_d;

  logic       ph_setup, ph_access, ph_orphan, sel_any, multi_sel;
  logic       capture, track, complete, unstable;
  logic [7:0] new_err;
  logic [7:0] wait8;

  assign sel_any   = |PSEL;
  assign ph_setup  = sel_any && !PENABLE;
  assign ph_access = sel_any && PENABLE;
  assign ph_orphan = !sel_any && PENABLE;
  // more than one bit set <=> clearing the lowest set bit leaves something
  assign multi_sel = |(PSEL & (PSEL - NUM_SEL'(1)));

  assign unstable = (PADDR != cap_addr_q) || (PWRITE != cap_write_q) ||
                    (PSEL != cap_sel_q) || (PPROT != cap_prot_q) ||
                    (PSTRB != cap_strb_q) ||
                    (cap_write_q && (PWDATA != cap_wdata_q));

  assign wait8 = (|wait_q[15:8]) ? 8'hFF : wait_q[7:0];

  // next-state, error detection and statistics update for this bus sample
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    cap_addr_d  = cap_addr_q;
    cap_write_d = cap_write_q;
    cap_sel_d   = cap_sel_q;
    cap_prot_d  = cap_prot_q;
    cap_strb_d  = cap_strb_q;
    cap_wdata_d = cap_wdata_q;
    xfer_d      = xfer_q;
    slverr_d    = slverr_q;
    maxw_d      = maxw_q;
    new_err     = '0;
    capture     = 1'b0;
    track       = 1'b0;
    complete    = 1'b0;

    new_err[2] = ph_orphan;
    new_err[3] = multi_sel;
    new_err[5] = ph_access && !PWRITE && (|PSTRB);
    new_err[6] = ph_setup && PREADY;

    case (state_q)
      ST_IDLE: begin
        // an access with no preceding setup resyncs straight into ACCESS
        if (ph_setup) begin
          state_d = ST_SETUP;
          capture = 1'b1;
        end else if (ph_access) begin
          state_d = ST_ACCESS;
          capture = 1'b1;
        end
      end
      ST_SETUP: begin
        if (ph_access) begin
          track = 1'b1;
        end else begin
          new_err[0] = 1'b1;
          if (ph_setup) begin
            state_d = ST_SETUP;
            capture = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_ACCESS: begin
        if (ph_access) begin
          track = 1'b1;
        end else if (ph_setup) begin
          state_d = ST_SETUP;
          capture = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (track) begin
      new_err[1] = unstable;
      if (PREADY) begin
        // PENABLE is high at completion, so the bus cannot be in setup here
        complete = 1'b1;
        state_d  = ST_IDLE;
      end else begin
        state_d = ST_ACCESS;
        if (wait_q != 16'hFFFF) begin
          wait_d = wait_q + 16'd1;
          // equality fires on exactly one cycle of a stalled transfer
          new_err[4] = ((wait_q + 16'd1) == MAX_WAIT_L);
        end
      end
    end

    if (capture) begin
      wait_d      = '0;
      cap_addr_d  = PADDR;
      cap_write_d = PWRITE;
      cap_sel_d   = PSEL;
      cap_prot_d  = PPROT;
      cap_strb_d  = PSTRB;
      if (PWRITE) cap_wdata_d = PWDATA;
    end

    if (complete) begin
      if (xfer_q != 16'hFFFF) xfer_d = xfer_q + 16'd1;
      if (PSLVERR && (slverr_q != 16'hFFFF)) slverr_d = slverr_q + 16'd1;
      if (wait8 > maxw_q) maxw_d = wait8;
`ifdef APB_ADDR_MAP_CHECK_EN
      new_err[7] = (PADDR <= ADDR_WIDTH'(LEGAL_ADDR_MAX)) ? PSLVERR : !PSLVERR;
`endif
    end

    err_d = (err_q & ~err_clr) | new_err;
  end

`ifndef APB_ADDR_MAP_CHECK_EN
  logic unused_legal_addr_max;
  assign unused_legal_addr_max = (LEGAL_ADDR_MAX < 0);
`endif

  // all monitor state, synchronously reset
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= ST_IDLE;
      wait_q      <= '0;
      cap_addr_q  <= '0;
      cap_write_q <= 1'b0;
      cap_sel_q   <= '0;
      cap_prot_q  <= '0;
      cap_strb_q  <= '0;
      cap_wdata_q <= '0;
      err_q       <= '0;
      xfer_q      <= '0;
      slverr_q    <= '0;
      maxw_q      <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      cap_addr_q  <= cap_addr_d;
      cap_write_q <= cap_write_d;
      cap_sel_q   <= cap_sel_d;
      cap_prot_q  <= cap_prot_d;
      cap_strb_q  <= cap_strb_d;
      cap_wdata_q <= cap_wdata_d;
      err_q       <= err_d;
      xfer_q      <= xfer_d;
      slverr_q    <= slverr_d;
      maxw_q      <= maxw_d;
    end
  end

`ifndef SYNTHESIS
  // read data must be driven to known values when a read completes
  always_ff @(posedge PCLK) begin
    if (!PRESET && complete && !PWRITE) assert (!$isunknown(PRDATA));
  end
`endif

  logic unused_prdata;
  assign unused_prdata = ^PRDATA;

  assign err_sticky    = err_q;
  assign err_irq       = |err_q;
  assign mon_state     = state_q;
  assign xfer_cnt      = xfer_q;
  assign slverr_cnt    = slverr_q;
  assign max_wait_seen = maxw_q;

endmodule

// File: tb/tb_apb4_protocol_monitor.sv
// Directed bench for apb4_protocol_monitor (MAX_WAIT overridden to 4).
module tb_apb4_protocol_monitor;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 4;
`ifdef APB_ADDR_MAP_CHECK_EN
  localparam logic [7:0] AM = 8'h80;
`else
  localparam logic [7:0] AM = 8'h00;
`endif

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic [AW-1:0] PADDR;
  logic [NS-1:0] PSEL;
  logic          PENABLE, PWRITE, PREADY, PSLVERR;
  logic [DW-1:0] PWDATA, PRDATA;
  logic [DW/8-1:0] PSTRB;
  logic [2:0]    PPROT;
  logic [7:0]    err_clr;
  logic [7:0]    err_sticky;
  logic          err_irq;
  logic [1:0]    mon_state;
  logic [15:0]   xfer_cnt, slverr_cnt;
  logic [7:0]    max_wait_seen;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [7:0]  err;
    logic [1:0]  st;
    logic [15:0] xf;
    logic [15:0] se;
    logic [7:0]  mw;
  } exp_t;
  exp_t sb[$];

  apb4_protocol_monitor #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SEL(NS), .MAX_WAIT(4), .LEGAL_ADDR_MAX(255)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PREADY(PREADY), .PSLVERR(PSLVERR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PSTRB(PSTRB), .PPROT(PPROT), .err_clr(err_clr),
    .err_sticky(err_sticky), .err_irq(err_irq), .mon_state(mon_state),
    .xfer_cnt(xfer_cnt), .slverr_cnt(slverr_cnt), .max_wait_seen(max_wait_seen)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input string field, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
    end
  endtask

  // drive one bus sample, queue its expected result, clock it, compare
  task automatic step(input string tag, input logic [NS-1:0] sel, input logic en,
                      input logic wr, input logic rdy, input logic slv,
                      input logic [AW-1:0] addr, input logic [3:0] strb, input logic [7:0] clr,
                      input logic [7:0] e_err, input logic [1:0] e_st, input logic [15:0] e_xf,
                      input logic [15:0] e_se, input logic [7:0] e_mw);
    exp_t e;
    PSEL = sel; PENABLE = en; PWRITE = wr; PREADY = rdy; PSLVERR = slv;
    PADDR = addr; PSTRB = strb; err_clr = clr;
    PWDATA = addr ^ 32'hA5A5_0000;
    sb.push_back('{tag, e_err, e_st, e_xf, e_se, e_mw});
    @(posedge PCLK);
    #1;
    if (sb.size() == 0) begin
      checks++; failures++;
      $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk(e.tag, "err_sticky", 32'(err_sticky), 32'(e.err));
      chk(e.tag, "err_irq", 32'(err_irq), 32'(|e.err));
      chk(e.tag, "mon_state", 32'(mon_state), 32'(e.st));
      chk(e.tag, "xfer_cnt", 32'(xfer_cnt), 32'(e.xf));
      chk(e.tag, "slverr_cnt", 32'(slverr_cnt), 32'(e.se));
      chk(e.tag, "max_wait", 32'(max_wait_seen), 32'(e.mw));
    end
  endtask

  initial begin
    PRESET = 1'b1; PPROT = 3'b010; PRDATA = 32'h1234_5678;
    PSEL = '0; PENABLE = 0; PWRITE = 0; PREADY = 0; PSLVERR = 0;
    PADDR = '0; PSTRB = '0; PWDATA = '0; err_clr = '0;
    #2;
    step("reset", 4'b0000, 0, 0, 0, 0, 32'h0, 4'h0, 8'h00, 8'h00, 2'd0, 16'd0, 16'd0, 8'd0);
    PRESET = 1'b0;

    // zero-wait write, then 3-wait read back-to-back
    step("wr_setup",  4'b0001, 0, 1, 0, 0, 32'h10, 4'hF, 8'h00, 8'h00, 2'd1, 16'd0, 16'd0, 8'd0);
    step("wr_access", 4'b0001, 1, 1, 1, 0, 32'h10, 4'hF, 8'h00, 8'h00, 2'd0, 16'd1, 16'd0, 8'd0);
    step("rd_setup",  4'b0010, 0, 0, 0, 0, 32'h20, 4'h0, 8'h00, 8'h00, 2'd1, 16'd1, 16'd0, 8'd0);
    for (int i = 0; i < 3; i++)
      step("rd_wait", 4'b0010, 1, 0, 0, 0, 32'h20, 4'h0, 8'h00, 8'h00, 2'd2, 16'd1, 16'd0, 8'd0);
    step("rd_done",   4'b0010, 1, 0, 1, 0, 32'h20, 4'h0, 8'h00, 8'h00, 2'd0, 16'd2, 16'd0, 8'd3);
    step("idle",      4'b0000, 0, 0, 0, 0, 32'h0,  4'h0, 8'h00, 8'h00, 2'd0, 16'd2, 16'd0, 8'd3);

    // address changes between setup and access
    step("unst_setup",  4'b0001, 0, 1, 0, 0, 32'h40, 4'hF, 8'h00, 8'h00, 2'd1, 16'd2, 16'd0, 8'd3);
    step("unst_access", 4'b0001, 1, 1, 1, 0, 32'h44, 4'hF, 8'h00, 8'h02, 2'd0, 16'd3, 16'd0, 8'd3);
    step("unst_clr",    4'b0000, 0, 0, 0, 0, 32'h0,  4'h0, 8'h02, 8'h00, 2'd0, 16'd3, 16'd0, 8'd3);

    // timeout after 4 waits, flagged once (cleared on wait 5, stays clear)
    step("to_setup", 4'b0001, 0, 0, 0, 0, 32'h08, 4'h0, 8'h00, 8'h00, 2'd1, 16'd3, 16'd0, 8'd3);
    step("to_w1",    4'b0001, 1, 0, 0, 0, 32'h08, 4'h0, 8'h00, 8'h00, 2'd2, 16'd3, 16'd0, 8'd3);
    step("to_w2",    4'b0001, 1, 0, 0, 0, 32'h08, 4'h0, 8'h00, 8'h00, 2'd2, 16'd3, 16'd0, 8'd3);
    step("to_w3",    4'b0001, 1, 0, 0, 0, 32'h08, 4'h0, 8'h00, 8'h00, 2'd2, 16'd3, 16'd0, 8'd3);
    step("to_w4",    4'b0001, 1, 0, 0, 0, 32'h08, 4'h0, 8'h00, 8'h10, 2'd2, 16'd3, 16'd0, 8'd3);
    step("to_w5",    4'b0001, 1, 0, 0, 0, 32'h08, 4'h0, 8'h10, 8'h00, 2'd2, 16'd3, 16'd0, 8'd3);
    step("to_w6",    4'b0001, 1, 0, 0, 0, 32'h08, 4'h0, 8'h00, 8'h00, 2'd2, 16'd3, 16'd0, 8'd3);
    step("to_done",  4'b0001, 1, 0, 1, 0, 32'h08, 4'h0, 8'h00, 8'h00, 2'd0, 16'd4, 16'd0, 8'd6);

    // multi-select, then orphan enable abandoning the setup
    step("multi_sel", 4'b0011, 0, 0, 0, 0, 32'h0, 4'h0, 8'h00, 8'h08, 2'd1, 16'd4, 16'd0, 8'd6);
    step("orphan",    4'b0000, 1, 0, 0, 0, 32'h0, 4'h0, 8'h00, 8'h0D, 2'd0, 16'd4, 16'd0, 8'd6);
    step("clr_all",   4'b0000, 0, 0, 0, 0, 32'h0, 4'h0, 8'hFF, 8'h00, 2'd0, 16'd4, 16'd0, 8'd6);

    // address map: 0x100 OKAY and 0xFF SLVERR are both mismatches
    step("am_setup1", 4'b0001, 0, 0, 0, 0, 32'h100, 4'h0, 8'h00, 8'h00, 2'd1, 16'd4, 16'd0, 8'd6);
    step("am_done1",  4'b0001, 1, 0, 1, 0, 32'h100, 4'h0, 8'h00, AM,    2'd0, 16'd5, 16'd0, 8'd6);
    step("am_clr1",   4'b0000, 0, 0, 0, 0, 32'h0,   4'h0, 8'hFF, 8'h00, 2'd0, 16'd5, 16'd0, 8'd6);
    step("am_setup2", 4'b0001, 0, 0, 0, 0, 32'hFF,  4'h0, 8'h00, 8'h00, 2'd1, 16'd5, 16'd0, 8'd6);
    step("am_done2",  4'b0001, 1, 0, 1, 1, 32'hFF,  4'h0, 8'h00, AM,    2'd0, 16'd6, 16'd1, 8'd6);
    step("am_clr2",   4'b0000, 0, 0, 0, 0, 32'h0,   4'h0, 8'hFF, 8'h00, 2'd0, 16'd6, 16'd1, 8'd6);

    // set beats clear on bit 0; clear alone works; then reset mid-access
    step("sc_setup",  4'b0001, 0, 0, 0, 0, 32'h0, 4'h0, 8'h00, 8'h00, 2'd1, 16'd6, 16'd1, 8'd6);
    step("sc_resetup",4'b0001, 0, 0, 0, 0, 32'h0, 4'h0, 8'h00, 8'h01, 2'd1, 16'd6, 16'd1, 8'd6);
    step("sc_setclr", 4'b0001, 0, 0, 0, 0, 32'h0, 4'h0, 8'h01, 8'h01, 2'd1, 16'd6, 16'd1, 8'd6);
    step("sc_clr",    4'b0001, 1, 0, 0, 0, 32'h0, 4'h0, 8'h01, 8'h00, 2'd2, 16'd6, 16'd1, 8'd6);
    step("sc_w2",     4'b0001, 1, 0, 0, 0, 32'h0, 4'h0, 8'h00, 8'h00, 2'd2, 16'd6, 16'd1, 8'd6);
    step("sc_w3",     4'b0001, 1, 0, 0, 0, 32'h0, 4'h0, 8'h00, 8'h00, 2'd2, 16'd6, 16'd1, 8'd6);
    step("sc_w4",     4'b0001, 1, 0, 0, 0, 32'h0, 4'h0, 8'h00, 8'h10, 2'd2, 16'd6, 16'd1, 8'd6);
    PRESET = 1'b1;
    step("rst_mid",   4'b0001, 1, 0, 1, 1, 32'h0, 4'h0, 8'h00, 8'h00, 2'd0, 16'd0, 16'd0, 8'd0);
    PRESET = 1'b0;
    step("rst_idle",  4'b0000, 0, 0, 0, 0, 32'h0, 4'h0, 8'h00, 8'h00, 2'd0, 16'd0, 16'd0, 8'd0);

    // ready during setup, strobes on a read access
    step("rdy_setup", 4'b0001, 0, 0, 1, 0, 32'h4, 4'h3, 8'h00, 8'h40, 2'd1, 16'd0, 16'd0, 8'd0);
    step("strb_read", 4'b0001, 1, 0, 1, 0, 32'h4, 4'h3, 8'h00, 8'h60, 2'd0, 16'd1, 16'd0, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
